// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the byte-sequencing data memory controller.
// Imported by mem_addr_gen and mem_seq_ctrl.
package mem_seq_pkg;

   localparam int BYTES_PER_WORD      = 4;
   localparam int DEFAULT_BASE_OFFSET = 1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_e;

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Bus bundles for mem_seq_ctrl: the MEM-stage request side and the byte SRAM side.
// Handshake: the MEM stage raises mem_r_en/mem_w_en and holds them with alu_res/Val_Rm
// stable until it sees ready=1; the cycle with ready=1 completes the word transfer.
interface mem_req_if #(
   parameter int WORD_W = 32
);
   logic              mem_r_en;
   logic              mem_w_en;
   logic [WORD_W-1:0] alu_res;
   logic [WORD_W-1:0] Val_Rm;
   logic [WORD_W-1:0] res_data;
   logic              ready;
   logic              addr_err;

   modport master (
      output mem_r_en, mem_w_en, alu_res, Val_Rm,
      input  res_data, ready, addr_err
   );

   modport slave (
      input  mem_r_en, mem_w_en, alu_res, Val_Rm,
      output res_data, ready, addr_err
   );
endinterface

interface sram_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_wdata;
   logic              sram_we;
   logic              sram_oe;
   logic [7:0]        sram_rdata;

   modport master (
      output sram_addr, sram_wdata, sram_we, sram_oe,
      input  sram_rdata
   );

   modport slave (
      input  sram_addr, sram_wdata, sram_we, sram_oe,
      output sram_rdata
   );
endinterface

// File: rtl/mem_addr_gen.sv
// Word-aligns the effective address and rebases it onto the data segment;
// flags any word that would not fit entirely inside the memory (wrap included).
module mem_addr_gen
   import mem_seq_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int MEM_BYTES   = 256,
   parameter int ADDR_W      = 8,
   parameter int BASE_OFFSET = DEFAULT_BASE_OFFSET
) (
   input  logic [WORD_W-1:0] alu_res,
   output logic [ADDR_W-1:0] base,
   output logic              out_of_range
);

   logic [WORD_W-1:0] aligned;
   logic [WORD_W-1:0] translated;

   always_comb begin
      aligned      = alu_res & ~WORD_W'(BYTES_PER_WORD - 1);
      // Modulo subtraction: addresses below the segment wrap high and fail the range test.
      translated   = aligned - WORD_W'(BASE_OFFSET);
      out_of_range = translated > WORD_W'(MEM_BYTES - BYTES_PER_WORD);
      base         = translated[ADDR_W-1:0];
   end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into four little-endian byte accesses on an
// 8-bit SRAM, freezing the pipeline meanwhile. MEM_WAIT_EN stretches each byte access.
module mem_seq_ctrl
   import mem_seq_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int MEM_BYTES   = 256,
   parameter int ADDR_W      = $clog2(MEM_BYTES),
   parameter int BASE_OFFSET = DEFAULT_BASE_OFFSET
`ifdef MEM_WAIT_EN
   ,
   parameter int WAIT_CYCLES = 2
`endif
) (
   input  logic        clk,
   input  logic        rst,
   mem_req_if.slave    req,
   sram_if.master      sram,
   output state_e      dbg_state
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [WORD_W-1:0] shadow_q, shadow_d;
   logic [WORD_W-1:0] res_data_q, res_data_d;
   logic              oor_q, oor_d;
   logic              addr_err_q, addr_err_d;
   logic              sram_we_q, sram_we_d;
   logic              sram_oe_q, sram_oe_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [7:0]        sram_wdata_q, sram_wdata_d;

   logic [ADDR_W-1:0] ag_base;
   logic              ag_oor;
   logic              req_any;
   logic              step_done;
   logic              issue;
   logic [1:0]        issue_cnt;
   logic              ready_c;

   mem_addr_gen #(
      .WORD_W      (WORD_W),
      .MEM_BYTES   (MEM_BYTES),
      .ADDR_W      (ADDR_W),
      .BASE_OFFSET (BASE_OFFSET)
   ) u_addr_gen (
      .alu_res      (req.alu_res),
      .base         (ag_base),
      .out_of_range (ag_oor)
   );

   assign req_any = req.mem_r_en | req.mem_w_en;

`ifdef MEM_WAIT_EN
   localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // A byte window closes on its last wait cycle; read data is captured only then.
   assign step_done = (wait_q == WAIT_W'(WAIT_CYCLES));

   always_comb begin
      wait_d = '0;
      if (state_q == ACCESS && !step_done) begin
         wait_d = wait_q + 1'b1;
      end
   end
`else
   assign step_done = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      data_d       = data_q;
      shadow_d     = shadow_q;
      res_data_d   = res_data_q;
      oor_d        = oor_q;
      addr_err_d   = 1'b0;
      sram_we_d    = 1'b0;
      sram_oe_d    = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      issue        = 1'b0;
      issue_cnt    = 2'd0;

      case (state_q)
         IDLE: begin
            if (req_any) begin
               state_d   = ACCESS;
               op_d      = req.mem_w_en ? OP_STORE : OP_LOAD;
               base_d    = ag_base;
               data_d    = req.Val_Rm;
               oor_d     = ag_oor;
               cnt_d     = 2'd0;
               issue     = 1'b1;
               issue_cnt = 2'd0;
            end
         end
         ACCESS: begin
            if (sram_oe_q && step_done) begin
               shadow_d[{cnt_q, 3'b000} +: 8] = sram.sram_rdata;
            end
            if (!step_done) begin
               sram_we_d = sram_we_q;
               sram_oe_d = sram_oe_q;
            end else if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
               state_d    = DONE;
               addr_err_d = oor_q;
               if (op_q == OP_LOAD) begin
                  res_data_d = oor_q ? '0 : shadow_d;
               end
            end else begin
               cnt_d     = cnt_q + 2'd1;
               issue     = 1'b1;
               issue_cnt = cnt_q + 2'd1;
            end
         end
         DONE: begin
            // The request still on the bus belongs to the finished instruction.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         sram_we_d    = (op_d == OP_STORE) && !oor_d;
         sram_oe_d    = (op_d == OP_LOAD) && !oor_d;
         sram_addr_d  = base_d + ADDR_W'(issue_cnt);
         sram_wdata_d = data_d[{issue_cnt, 3'b000} +: 8];
      end
   end

   always_comb begin
      ready_c = 1'b0;
      case (state_q)
         IDLE:    ready_c = ~req_any;
         ACCESS:  ready_c = 1'b0;
         DONE:    ready_c = 1'b1;
         default: ready_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= OP_LOAD;
         cnt_q        <= 2'd0;
         base_q       <= '0;
         data_q       <= '0;
         shadow_q     <= '0;
         res_data_q   <= '0;
         oor_q        <= 1'b0;
         addr_err_q   <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_oe_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
`ifdef MEM_WAIT_EN
         wait_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         data_q       <= data_d;
         shadow_q     <= shadow_d;
         res_data_q   <= res_data_d;
         oor_q        <= oor_d;
         addr_err_q   <= addr_err_d;
         sram_we_q    <= sram_we_d;
         sram_oe_q    <= sram_oe_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
`ifdef MEM_WAIT_EN
         wait_q       <= wait_d;
`endif
      end
   end

   assign req.res_data    = res_data_q;
   assign req.ready       = ready_c;
   assign req.addr_err    = addr_err_q;
   assign sram.sram_addr  = sram_addr_q;
   assign sram.sram_wdata = sram_wdata_q;
   assign sram.sram_we    = sram_we_q;
   assign sram.sram_oe    = sram_oe_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: directed vector table, reset/flush sequences
// and random loads/stores against a byte-array reference model.
module tb_mem_seq_ctrl;
   import mem_seq_pkg::*;

`ifdef MEM_WAIT_EN
   localparam int WPB = 3;
`else
   localparam int WPB = 1;
`endif
   localparam int MEMB = 256;

   logic   clk = 1'b0;
   logic   rst;
   state_e dbg_state;
   int     checks = 0;
   int     errors = 0;

   mem_req_if #(.WORD_W(32)) req();
   sram_if    #(.ADDR_W(8))  sram();

   mem_seq_ctrl #(
      .WORD_W      (32),
      .MEM_BYTES   (MEMB),
      .ADDR_W      (8),
      .BASE_OFFSET (1024)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .sram      (sram),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- byte SRAM (combinational read) ----------------
   logic [7:0] sram_mem [MEMB];
   assign sram.sram_rdata = sram_mem[sram.sram_addr];
   always @(posedge clk) begin
      if (sram.sram_we) sram_mem[sram.sram_addr] <= sram.sram_wdata;
   end

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [MEMB];
   logic [31:0] ref_res;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] ref_base(input logic [31:0] a);
      return a - (a % 4) - 32'd1024;
   endfunction

   function automatic logic ref_in_range(input logic [31:0] a);
      return ref_base(a) <= 32'(MEMB - 4);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic use_tab, input logic [31:0] tab_res, input logic tab_err,
                         input string name);
      logic [31:0] b;
      logic        inr;
      logic [31:0] m_res;
      logic [31:0] e_res;
      logic        e_err;
      int          cyc;
      int          k;
      b   = ref_base(a);
      inr = ref_in_range(a);
      m_res = ref_res;
      if (!w) m_res = inr ? {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]} : 32'd0;
      e_res = use_tab ? tab_res : m_res;
      e_err = use_tab ? tab_err : !inr;
      exp_q.push_back(e_res);
      if (w && inr) for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
      ref_res = e_res;

      @(negedge clk);
      req.mem_r_en = r;
      req.mem_w_en = w;
      req.alu_res  = a;
      req.Val_Rm   = d;
      cyc = 0;
      #1;
      while (!req.ready && cyc < 100) begin
         chk({name, ".err_busy"}, 32'(req.addr_err), 32'd0);
         if (cyc == 0) begin
            chk({name, ".strobe_idle"}, {30'd0, sram.sram_we, sram.sram_oe}, 32'd0);
         end else begin
            k = (cyc - 1) / WPB;
            if (k > 3) k = 3;
            chk({name, ".we"}, 32'(sram.sram_we), 32'(w && inr));
            chk({name, ".oe"}, 32'(sram.sram_oe), 32'(!w && inr));
            if (inr) chk({name, ".addr"}, 32'(sram.sram_addr), 32'(b[7:0] + 8'(k)));
            if (w && inr) chk({name, ".wdata"}, 32'(sram.sram_wdata), 32'(d[8*k +: 8]));
         end
         cyc++;
         @(negedge clk);
         #1;
      end
      chk({name, ".latency"}, 32'(cyc), 32'(4*WPB + 1));
      chk({name, ".res_data"}, req.res_data, exp_q.pop_front());
      chk({name, ".addr_err"}, 32'(req.addr_err), 32'(e_err));
      chk({name, ".strobe_done"}, {30'd0, sram.sram_we, sram.sram_oe}, 32'd0);
      req.mem_r_en = 1'b0;
      req.mem_w_en = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] res;
      logic        err;
   } vec_t;

   vec_t tab [10];

   initial begin
      logic [1:0] rw;
      logic [31:0] a;
      int sel;

      tab[0] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tab[1] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tab[2] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tab[3] = '{1'b1, 1'b0, 32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tab[4] = '{1'b1, 1'b1, 32'h0000_0404, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tab[5] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 32'h1122_3344, 1'b0};
      tab[6] = '{1'b0, 1'b1, 32'h0000_04FF, 32'hCAFE_F00D, 32'h1122_3344, 1'b0};
      tab[7] = '{1'b1, 1'b0, 32'h0000_04FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      tab[8] = '{1'b0, 1'b1, 32'h0000_03FF, 32'h1234_5678, 32'hCAFE_F00D, 1'b1};
      tab[9] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

      for (int i = 0; i < MEMB; i++) begin
         sram_mem[i] <= 8'($urandom);
      end
      req.mem_r_en = 1'b0;
      req.mem_w_en = 1'b0;
      req.alu_res  = '0;
      req.Val_Rm   = '0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < MEMB; i++) ref_mem[i] = sram_mem[i];
      ref_res = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.res_data", req.res_data, 32'd0);
      chk("rst.addr_err", 32'(req.addr_err), 32'd0);
      chk("rst.strobes", {30'd0, sram.sram_we, sram.sram_oe}, 32'd0);
      chk("rst.addr", 32'(sram.sram_addr), 32'd0);
      chk("rst.wdata", 32'(sram.sram_wdata), 32'd0);
      chk("rst.ready", 32'(req.ready), 32'd1);
      chk("rst.state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(tab[i].r, tab[i].w, tab[i].a, tab[i].d, 1'b1, tab[i].res, tab[i].err,
                $sformatf("tab%0d", i));
      end

      // Reset during a store: two bytes land, strobes drop at once.
      @(negedge clk);
      req.mem_w_en = 1'b1;
      req.alu_res  = 32'h0000_0400;
      req.Val_Rm   = 32'h0102_0304;
      repeat (2*WPB + 1) @(negedge clk);
      #1;
      chk("rstmid.we_before", 32'(sram.sram_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid.we", 32'(sram.sram_we), 32'd0);
      chk("rstmid.oe", 32'(sram.sram_oe), 32'd0);
      chk("rstmid.state", 32'(dbg_state), 32'(IDLE));
      chk("rstmid.ready_req", 32'(req.ready), 32'd0);
      req.mem_w_en = 1'b0;
      #1;
      chk("rstmid.ready_idle", 32'(req.ready), 32'd1);
      chk("rstmid.res_data", req.res_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ref_mem[0] = 8'h04;
      ref_mem[1] = 8'h03;
      ref_res = 32'd0;
      run_op(1'b1, 1'b0, 32'h0000_0400, 32'd0, 1'b1, 32'hDEAD_0304, 1'b0, "rstmid.load");

      // Flush: enables drop one cycle into the store; the write still completes.
      @(negedge clk);
      req.mem_w_en = 1'b1;
      req.alu_res  = 32'h0000_0408;
      req.Val_Rm   = 32'h5566_7788;
      @(negedge clk);
      req.mem_w_en = 1'b0;
      #1;
      chk("flush.ready", 32'(req.ready), 32'd0);
      repeat (4*WPB + 2) @(negedge clk);
      for (int i = 0; i < 4; i++) ref_mem[8+i] = 8'(32'h5566_7788 >> (8*i));
      run_op(1'b1, 1'b0, 32'h0000_0408, 32'd0, 1'b1, 32'h5566_7788, 1'b0, "flush.load");

      // Random traffic against the model.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0)      a = $urandom;
         else if (sel == 1) a = 32'h0000_0400 + $urandom_range(0, 300);
         else               a = 32'h0000_0400 + $urandom_range(0, MEMB - 1);
         rw = 2'($urandom_range(1, 3));
         run_op(rw[0], rw[1], a, $urandom, 1'b0, 32'd0, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Sequences 32-bit load/store requests from the MEM pipeline stage onto an 8-bit-wide data memory as four byte transactions, little-endian.
- Translates addresses: word-align, then subtract the data-segment base.
- Drives `ready` low to freeze the pipeline until the word access completes.
- Sits between the MEM stage and the byte memory array.

Parameters:
- WORD_W, 32, data/address word width
- MEM_BYTES, 256, byte capacity of the data memory
- ADDR_W, $clog2(MEM_BYTES), byte address width on the memory port
- BASE_OFFSET, 1024, byte address mapped to memory location 0
- WAIT_CYCLES, 2, extra cycles per byte; used only when MEM_WAIT_EN is defined

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mem_r_en  in  1  load request, held by the MEM stage until ready
- mem_w_en  in  1  store request, held by the MEM stage until ready
- alu_res  in  WORD_W  effective byte address
- Val_Rm  in  WORD_W  store data
- res_data  out  WORD_W  load result; held until the next load completes
- ready  out  1  0 = freeze pipeline
- addr_err  out  1  one-cycle pulse in DONE when the address was out of range
- sram_addr  out  ADDR_W  byte address
- sram_wdata  out  8  write byte
- sram_we  out  1  byte write strobe
- sram_oe  out  1  byte read enable
- sram_rdata  in  8  read byte; combinational read, valid in the same cycle as sram_oe

Behaviour:
- Interface: single clock `clk`; `rst` is asynchronous, active-high.
- Reset values:
  - state = IDLE
  - res_data = 0, addr_err = 0
  - sram_we = 0, sram_oe = 0, sram_addr = 0, sram_wdata = 0
  - ready follows the combinational rule below
- Address: base = {alu_res[WORD_W-1:2], 2'b00} - BASE_OFFSET, computed modulo 2^WORD_W.
  - Out of range if base > MEM_BYTES-4 as unsigned; this includes underflow wrap.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en).
  - On a request, latch base, Val_Rm, op, and range flag; byte count cnt = 0; go to ACCESS.
  - If both enables are high, the op is a store (write priority).
- ACCESS (in range):
  - sram_addr = base[ADDR_W-1:0] + cnt.
  - Store: sram_we = 1, sram_wdata = data[8*cnt +: 8].
  - Load: sram_oe = 1; sram_rdata is captured into a shadow register byte lane cnt at the clock edge.
  - cnt increments each cycle; after cnt = 3, go to DONE.
  - ready = 0 throughout.
- ACCESS (out of range): no strobes asserted; still takes 4 cycles, so latency is constant.
- DONE:
  - ready = 1.
  - Load: res_data <= shadow register (0 if out of range).
  - addr_err = range flag.
  - The still-asserted request belongs to the finished instruction and is ignored; return to IDLE.
- Latency: request to ready-high = 5 cycles (IDLE + 4 ACCESS), ready high in the 6th cycle (DONE).
- res_data during a store and when idle: holds its previous value.
- Enables dropping mid-ACCESS (pipeline flush): the access completes anyway; the write is not aborted.
- rst mid-ACCESS: strobes drop immediately and the FSM returns to IDLE. A partial store (some bytes written) is accepted.
- sram_we and sram_oe are never high together.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: each byte is held for WAIT_CYCLES+1 cycles via a wait counter.
  - Strobe, address and data stay stable for that whole window.
  - Read data is captured on the last cycle of the window.
  - Latency = 4*(WAIT_CYCLES+1)+1 cycles to DONE.
- Undefined: one cycle per byte; WAIT_CYCLES is ignored and no wait counter is synthesized.

Decomposition:
- Package mem_seq_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - BYTES_PER_WORD = 4
  - default BASE_OFFSET
  - op enum {OP_LOAD, OP_STORE}
- Sub-module mem_addr_gen (combinational): alu_res -> aligned, translated base plus out_of_range flag.

Test Plan:
- Store alu_res=0x400, Val_Rm=0xDEADBEEF:
  - sram_we high 4 cycles, addr 0..3, wdata EF, BE, AD, DE.
  - ready low 5 cycles, then high 1 cycle.
- Load from 0x403 after that store: alignment gives addr 0..3; res_data = 0xDEADBEEF in DONE; sram_we never high.
- alu_res=0x3FC: underflow; no strobes, addr_err pulses, load res_data = 0. Repeat with 0x400+MEM_BYTES: same result.
- mem_r_en and mem_w_en both high, alu_res=0x404, Val_Rm=0x11223344: store to addr 4..7; sram_oe stays 0.
- rst pulsed after 2 store bytes: FSM returns to IDLE, strobes 0 asynchronously; the next load of 0x400 returns 2 new bytes plus 2 old bytes.
- With MEM_WAIT_EN and WAIT_CYCLES=2: each address held 3 cycles; ready high at cycle 13; load data is correct.
